muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning operand and HI/LO width (even, 8..64).
REQ-002 The block SHALL have parameter CNTW, default $clog2(W)+1, meaning iteration counter width.
REQ-003 iCLK  input  1  clock; all state updates on the rising edge.
REQ-004 iRST  input  1  reset, synchronous, active-high.
REQ-005 iStart  input  1  request strobe, sampled on the rising edge.
REQ-006 iOp  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
REQ-007 iA, iB  input  W each  operands; iA is the dividend or multiplicand, and the MTHI/MTLO source.
REQ-008 iAbort  input  1  abandons the operation in flight.
REQ-009 oHI, oLO  output  W each  architectural HI and LO registers.
REQ-010 oBusy  output  1  high while an iterative operation is in flight.
REQ-011 oDone  output  1  one-cycle completion pulse.

Function
REQ-012 FSM states SHALL be IDLE, MUL, DIV, FIX and DONE.
REQ-013 A request SHALL be accepted only in IDLE or DONE; iStart in MUL, DIV or FIX SHALL be ignored.
REQ-014 On accept, operands SHALL be latched internally; later changes to iA/iB SHALL not affect the result.
REQ-015 MTHI/MTLO accept SHALL write iA to HI/LO at that edge; the FSM SHALL stay in IDLE, with no oBusy and no oDone.
REQ-016 MULT/MULTU/DIV/DIVU accept SHALL go to MUL or DIV; signed operations first take magnitudes and record the result signs.
REQ-017 MUL SHALL run radix-2 shift-add for exactly W cycles, then go to FIX.
REQ-018 DIV SHALL run restoring division for exactly W cycles, then go to FIX.
REQ-019 FIX SHALL apply sign correction in one cycle, update HI/LO, and go to DONE.
REQ-020 Accept to oDone SHALL take W+2 cycles; oBusy SHALL be high for exactly the W+1 cycles of MUL/DIV plus FIX.
REQ-021 DONE SHALL last one cycle with oDone=1, then go to IDLE, or accept a new request in that same cycle.
REQ-022 Multiply results: {HI,LO} = full 2W-bit product, signed for MULT and unsigned for MULTU.
REQ-023 Divide results: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-024 Divide by zero SHALL skip DIV, go to FIX, and give HI=iA, LO=all-ones; oDone SHALL follow 2 cycles after accept.
REQ-025 Signed DIV of most-negative by -1 SHALL give LO=most-negative, HI=0, with no exception.
REQ-026 HI/LO SHALL change only at FIX or MTHI/MTLO; intermediate values SHALL never be visible on oHI/oLO.
REQ-027 iAbort in MUL, DIV or FIX SHALL return to IDLE on the next edge, with HI/LO unchanged, no oDone, and oBusy low.
REQ-028 iAbort together with an accept in IDLE/DONE SHALL let iAbort win: the request is dropped.
REQ-029 iAbort in IDLE SHALL have no effect.
REQ-030 Ops 6 and 7 SHALL be accepted as no-ops with no state change.

Reset
REQ-031 iRST SHALL take priority over iStart and iAbort.
REQ-032 iRST SHALL force state IDLE, HI=0, LO=0, oBusy=0, oDone=0, and clear the counter and datapath registers.
REQ-033 iRST mid-operation SHALL discard the operation with no oDone.
REQ-034 The block SHALL have no initial blocks; reset is the only initialisation.

Configuration
REQ-035 With MULDIV_FAST_MULT_EN defined, MULT/MULTU SHALL use a single-cycle array product from IDLE to DONE: HI/LO are written on the accept edge and oDone is high the next cycle, with oBusy never asserted.
REQ-036 Without MULDIV_FAST_MULT_EN, multiply SHALL use the iterative path of REQ-017 and REQ-020.
REQ-037 Division SHALL be iterative in both configurations.

Verification (W=32)
REQ-038 MULT with A=0xFFFFFFFE (-2), B=3 -> after 34 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA, oDone pulses once; with the macro, the same values after 1 cycle.
REQ-039 DIV with A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
REQ-040 DIV with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU with B=0 -> HI=A, LO=0xFFFFFFFF, and oDone 2 cycles after accept.
REQ-041 MTHI with A=0x1234, then DIV with iStart re-pulsed and iA changed mid-operation -> the re-pulse is ignored and the result uses the latched operands; HI reads 0x1234 until FIX.
REQ-042 iAbort at cycle 10 of DIV -> next cycle IDLE, oBusy=0, no oDone, HI/LO unchanged.
REQ-043 iRST at cycle 5 of MULTU -> next cycle HI=LO=0, oBusy=0; an immediate new request then completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: W-cycle shift-add multiply and restoring divide, then a sign-fix cycle; done W+2 cycles after accept.
// No backpressure: oBusy marks MUL/DIV/FIX, where iStart is ignored. Define MULDIV_FAST_MULT_EN for a single-cycle array multiply.
module muldiv_unit #(
    parameter int W    = 32,
    parameter int CNTW = $clog2(W) + 1
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic         iStart,
    input  logic [2:0]   iOp,
    input  logic [W-1:0] iA,
    input  logic [W-1:0] iB,
    input  logic         iAbort,
    output logic [W-1:0] oHI,
    output logic [W-1:0] oLO,
    output logic         oBusy,
    output logic         oDone
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CNTW-1:0] r_cnt;
    logic [2*W-1:0]  r_p;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_a;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_dz;
    logic            r_is_div;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;

    logic            w_accept;
    logic            w_is_mul;
    logic            w_is_div;
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;
    logic [W:0]      w_mul_sum;
    logic [2*W-1:0]  w_mul_step;
    logic [W:0]      w_div_trial;
    logic [2*W-1:0]  w_div_step;
    logic [2*W-1:0]  w_prod;
    logic [W-1:0]    w_quo;
    logic [W-1:0]    w_rem;

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && iStart && !iAbort;
    assign w_is_mul = (iOp == OP_MULT) || (iOp == OP_MULTU);
    assign w_is_div = (iOp == OP_DIV) || (iOp == OP_DIVU);
    assign w_signed = (iOp == OP_MULT) || (iOp == OP_DIV);
    assign w_a_neg  = w_signed && iA[W-1];
    assign w_b_neg  = w_signed && iB[W-1];
    assign w_a_mag  = w_a_neg ? -iA : iA;
    assign w_b_mag  = w_b_neg ? -iB : iB;

    // r_p is {HI-half, LO-half}: multiplier shifts out of the low end, remainder/quotient shift up for divide.
    assign w_mul_sum   = {1'b0, r_p[2*W-1:W]} + (r_p[0] ? {1'b0, r_b} : {(W+1){1'b0}});
    assign w_mul_step  = {w_mul_sum, r_p[W-1:1]};
    assign w_div_trial = r_p[2*W-1:W-1] - {1'b0, r_b};
    assign w_div_step  = w_div_trial[W] ? {r_p[2*W-2:0], 1'b0}
                                        : {w_div_trial[W-1:0], r_p[W-2:0], 1'b1};

    assign w_prod = r_neg_q ? -r_p : r_p;
    assign w_quo  = r_neg_q ? -r_p[W-1:0] : r_p[W-1:0];
    assign w_rem  = r_neg_r ? -r_p[2*W-1:W] : r_p[2*W-1:W];

`ifdef MULDIV_FAST_MULT_EN
    logic [2*W-1:0] w_fast_a;
    logic [2*W-1:0] w_fast_b;
    logic [2*W-1:0] w_fast_prod;
    assign w_fast_a    = {{W{w_signed & iA[W-1]}}, iA};
    assign w_fast_b    = {{W{w_signed & iB[W-1]}}, iB};
    assign w_fast_prod = w_fast_a * w_fast_b;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_next = S_IDLE;
                if (w_accept) begin
                    if (w_is_mul)      w_next = FAST_MUL ? S_DONE : S_MUL;
                    else if (w_is_div) w_next = (iB == '0) ? S_FIX : S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (iAbort)                         w_next = S_IDLE;
                else if (r_cnt == CNTW'(W - 1))     w_next = S_FIX;
            end
            S_FIX:   w_next = iAbort ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        oBusy = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
        oDone = (r_state == S_DONE);
        oHI   = r_hi;
        oLO   = r_lo;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_cnt    <= '0;
            r_p      <= '0;
            r_b      <= '0;
            r_a      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_is_div <= 1'b0;
        end else if (w_accept && (w_is_div || (w_is_mul && !FAST_MUL))) begin
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_dz     <= w_is_div && (iB == '0);
            r_a      <= iA;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_b      <= w_is_div ? w_b_mag : w_a_mag;
            r_p      <= {{W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
        end else if (r_state == S_MUL) begin
            r_p   <= w_mul_step;
            r_cnt <= r_cnt + CNTW'(1);
        end else if (r_state == S_DIV) begin
            r_p   <= w_div_step;
            r_cnt <= r_cnt + CNTW'(1);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if ((r_state == S_FIX) && !iAbort) begin
            if (r_dz) begin
                r_hi <= r_a;
                r_lo <= {W{1'b1}};
            end else if (r_is_div) begin
                r_hi <= w_rem;
                r_lo <= w_quo;
            end else begin
                {r_hi, r_lo} <= w_prod;
            end
        end else if (w_accept) begin
            case (iOp)
                OP_MTHI: r_hi <= iA;
                OP_MTLO: r_lo <= iA;
`ifdef MULDIV_FAST_MULT_EN
                OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_fast_prod;
`endif
                default: ;
            endcase
        end
    end

endmodule
